alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width in bits (min 8).
REQ-002 SHALL have port: clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  operation request.
REQ-005 SHALL have port: in_ready  output  1  unit can accept a request.
REQ-006 SHALL have port: ALUControl  input  3  operation code, as produced by the decoder stage.
REQ-007 SHALL have port: A  input  WIDTH  operand A.
REQ-008 SHALL have port: B  input  WIDTH  operand B.
REQ-009 SHALL have port: out_valid  output  1  Result and flags valid.
REQ-010 SHALL have port: out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port: Result  output  WIDTH  operation result.
REQ-012 SHALL have ports: Zero, Negative, Carry, Overflow  output  1 each  status flags.
REQ-013 SHALL have port: illegal  output  1  unsupported ALUControl code, qualified by out_valid.

Function
REQ-014 SHALL implement FSM states IDLE, MUL, DONE; in_ready = 1 only in IDLE.
REQ-015 SHALL capture A, B, ALUControl on the clk edge with in_valid & in_ready.
REQ-016 SHALL decode codes: 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 101 SLT (signed), 110 MUL (see Configuration); all other codes are illegal.
REQ-017 SHALL, for single-cycle ops and illegal codes, go IDLE->DONE, with registered Result/flags and out_valid=1 in the cycle after acceptance (latency 1).
REQ-018 SHALL compute ADD/SUB modulo 2^WIDTH; SLT Result = zero-extended 1-bit (A < B signed).
REQ-019 SHALL set Carry = carry-out for ADD, NOT borrow (1 when A >= B unsigned) for SUB, 0 otherwise.
REQ-020 SHALL set Overflow for ADD when A,B share sign and Result sign differs; for SUB when A,B signs differ and Result sign differs from A; 0 otherwise.
REQ-021 SHALL set Zero = (Result == 0) and Negative = Result[WIDTH-1] for every op, including illegal.
REQ-022 SHALL return Result = 0 and illegal = 1 for illegal codes; illegal = 0 otherwise.
REQ-023 SHALL hold Result, flags, illegal and out_valid stable in DONE until out_ready = 1, then go DONE->IDLE on that edge.
REQ-024 SHALL ignore in_valid while not in IDLE; a request present in the same cycle as the DONE->IDLE transition is not accepted (accepted no earlier than the next cycle).
REQ-025 SHALL ignore operand/code changes after acceptance.

Reset
REQ-026 SHALL, on rst = 1 at a clk edge, enter IDLE and clear out_valid, Result, all flags, illegal and the MUL counter, aborting any in-flight operation, MUL included.
REQ-027 SHALL drive in_ready = 0 while rst = 1 and in_ready = 1 on the first cycle after rst deasserts.

Configuration
REQ-028 SHALL, with macro ALU_EXEC_MUL_EN defined, implement code 110 as an iterative shift-add multiply: IDLE->MUL, exactly WIDTH cycles in MUL, then DONE; out_valid rises WIDTH+1 cycles after acceptance; Result = low WIDTH bits of A*B; Carry = Overflow = 0.
REQ-029 SHALL, without ALU_EXEC_MUL_EN, treat code 110 as illegal (REQ-022), omit the MUL state and counter, and never spend more than one cycle between acceptance and DONE.

Verification
REQ-030 SHALL cover: ADD A=0x7FFFFFFF, B=1 -> one cycle later Result=0x80000000, Overflow=1, Negative=1, Carry=0, Zero=0.
REQ-031 SHALL cover: SUB A=5, B=5 -> Result=0, Zero=1, Carry=1; SUB A=3, B=5 -> Result=0xFFFFFFFE, Carry=0, Negative=1.
REQ-032 SHALL cover: SLT A=0xFFFFFFFF, B=1 -> Result=1; then code 100 -> Result=0, illegal=1, Zero=1.
REQ-033 SHALL cover backpressure: out_ready=0 for 5 cycles after out_valid -> outputs stable and in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-034 SHALL cover, with ALU_EXEC_MUL_EN: MUL A=1234, B=5678 -> out_valid 33 cycles after acceptance, Result=7006652; without the macro -> illegal=1 after 1 cycle.
REQ-035 SHALL cover: rst asserted 10 cycles into MUL -> next cycle IDLE, out_valid=0, Result=0, in_ready=1 once rst deasserts.

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked ALU with registered result and status flags.
// Single-cycle ops (ADD, SUB, AND, OR, SLT) produce a result one cycle after
// acceptance; the result is held until the consumer takes it.
// Optional feature macro: ALU_EXEC_MUL_EN -- when defined, code 110 runs an
// iterative shift-add multiply (WIDTH cycles); when undefined, 110 is illegal.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Negative,
  output logic             Carry,
  output logic             Overflow,
  output logic             illegal
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef ALU_EXEC_MUL_EN
    MUL  = 2'd1,
`endif
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               neg_q, neg_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;
  logic               ill_q, ill_d;

  // Combinational ALU results for the operation presented at the inputs
  logic [WIDTH:0]     sum_ext;
  logic [WIDTH:0]     dif_ext;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v, alu_ill, alu_is_mul;

`ifdef ALU_EXEC_MUL_EN
  localparam int CNT_W = $clog2(WIDTH);
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_step;
`endif

  // A request is only taken in IDLE, and never while reset is held
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign Result    = result_q;
  assign Zero      = zero_q;
  assign Negative  = neg_q;
  assign Carry     = carry_q;
  assign Overflow  = ovf_q;
  assign illegal   = ill_q;

  // Decode and evaluate the single-cycle operations; SUB carry is NOT borrow
  always_comb begin
    sum_ext    = {1'b0, A} + {1'b0, B};
    dif_ext    = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);
    alu_res    = '0;
    alu_c      = 1'b0;
    alu_v      = 1'b0;
    alu_ill    = 1'b0;
    alu_is_mul = 1'b0;
    case (ALUControl)
      3'b000: begin
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (A[WIDTH-1] == B[WIDTH-1]) && (sum_ext[WIDTH-1] != A[WIDTH-1]);
      end
      3'b001: begin
        alu_res = dif_ext[WIDTH-1:0];
        alu_c   = dif_ext[WIDTH];
        alu_v   = (A[WIDTH-1] != B[WIDTH-1]) && (dif_ext[WIDTH-1] != A[WIDTH-1]);
      end
      3'b010: alu_res = A & B;
      3'b011: alu_res = A | B;
      3'b101: alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
`ifdef ALU_EXEC_MUL_EN
      3'b110: alu_is_mul = 1'b1;
`endif
      default: alu_ill = 1'b1;
    endcase
  end

  // Next-state logic: accept in IDLE, iterate in MUL, hold in DONE
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    ill_d    = ill_q;
`ifdef ALU_EXEC_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
`ifdef ALU_EXEC_MUL_EN
          if (alu_is_mul) begin
            state_d  = MUL;
            mcand_d  = A;
            mplier_d = B;
            acc_d    = '0;
            cnt_d    = '0;
          end else
`endif
          begin
            state_d  = DONE;
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            neg_d    = alu_res[WIDTH-1];
            carry_d  = alu_c;
            ovf_d    = alu_v;
            ill_d    = alu_ill;
          end
        end
      end
`ifdef ALU_EXEC_MUL_EN
      MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          state_d  = DONE;
          cnt_d    = '0;
          result_d = acc_step;
          zero_d   = (acc_step == '0);
          neg_d    = acc_step[WIDTH-1];
          carry_d  = 1'b0;
          ovf_d    = 1'b0;
          ill_d    = 1'b0;
        end
      end
`endif
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      ill_q    <= ill_d;
`ifdef ALU_EXEC_MUL_EN
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Testbench for alu_exec_unit: directed vectors, multiply, backpressure,
// reset abort and randomized operations against an arithmetic reference model.
module tb_alu_exec_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]   ALUControl;
  logic [W-1:0] A, B, Result;
  logic         Zero, Negative, Carry, Overflow, illegal;

  int checks = 0;
  int errors = 0;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ALUControl(ALUControl), .A(A), .B(B), .out_valid(out_valid),
    .out_ready(out_ready), .Result(Result), .Zero(Zero), .Negative(Negative),
    .Carry(Carry), .Overflow(Overflow), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Reference model: {Result, Zero, Negative, Carry, Overflow, illegal}
  function automatic logic [W+4:0] model(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0]   r;
    logic [W:0]     s;
    logic [2*W-1:0] p;
    logic           cy, v, il;
    r = '0; cy = 1'b0; v = 1'b0; il = 1'b0; s = '0; p = '0;
    case (c)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; cy = s[W];
                  v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
      3'd1: begin r = a - b; cy = (a >= b);
                  v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd5: r = ($signed(a) < $signed(b)) ? 1 : 0;
`ifdef ALU_EXEC_MUL_EN
      3'd6: begin p = {{W{1'b0}}, a} * {{W{1'b0}}, b}; r = p[W-1:0]; end
`endif
      default: il = 1'b1;
    endcase
    return {r, (r == 0), r[W-1], cy, v, il};
  endfunction

  function automatic int model_lat(input logic [2:0] c);
`ifdef ALU_EXEC_MUL_EN
    if (c == 3'd6) return W + 1;
`endif
    return 1;
  endfunction

  // Present a request, wait for acceptance and then for out_valid.
  // lat counts edges from the accepting edge (1 = result right after it).
  task automatic run_op(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output logic [W+4:0] obs);
    int g;
    ALUControl = c; A = a; B = b; in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 100) begin @(posedge clk); #1; g++; end
    @(posedge clk); #1;
    in_valid = 1'b0; A = $urandom; B = $urandom; ALUControl = 3'($urandom);
    lat = 1;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    obs = {Result, Zero, Negative, Carry, Overflow, illegal};
    $display("op ctrl=%0d a=%h b=%h -> res=%h zncvi=%b lat=%0d", c, a, b, Result,
             {Zero, Negative, Carry, Overflow, illegal}, lat);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; ALUControl = '0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, Result, Zero, Negative, Carry, Overflow, illegal} !== '0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b Result=%h flags=%b expected all zero",
               in_ready, out_valid, Result, {Zero, Negative, Carry, Overflow, illegal});
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: in_ready=%b expected 1", in_ready);
    end
    $display("reset released");
  endtask

  task automatic test_directed();
    logic [2:0]   tc [9] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd5, 3'd4, 3'd2, 3'd3, 3'd7};
    logic [W-1:0] ta [9] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'd5, 32'd3, 32'hFFFFFFFF, 32'd1,
                             32'h0000F0F0, 32'h0000F0F0, 32'd9};
    logic [W-1:0] tb [9] = '{32'd1, 32'd1, 32'd5, 32'd5, 32'd1, 32'd2,
                             32'h0000FF00, 32'h0000FF00, 32'd9};
    logic [W-1:0] tr [9] = '{32'h80000000, 32'h0, 32'h0, 32'hFFFFFFFE, 32'h1, 32'h0,
                             32'h0000F000, 32'h0000FFF0, 32'h0};
    logic [4:0]   tf [9] = '{5'b01010, 5'b10100, 5'b10100, 5'b01000, 5'b00000, 5'b10001,
                             5'b00000, 5'b00000, 5'b10001};
    int lat;
    logic [W+4:0] obs;
    for (int i = 0; i < 9; i++) begin
      run_op(tc[i], ta[i], tb[i], lat, obs);
      checks++;
      if (obs !== {tr[i], tf[i]} || lat != 1) begin
        errors++;
        $display("FAIL directed_%0d: res=%h zncvi=%b lat=%0d expected res=%h zncvi=%b lat=1",
                 i, obs[W+4:5], obs[4:0], lat, tr[i], tf[i]);
      end
      release_result();
    end
  endtask

  task automatic test_mul();
    int lat;
    logic [W+4:0] obs;
    run_op(3'd6, 32'd1234, 32'd5678, lat, obs);
    checks++;
`ifdef ALU_EXEC_MUL_EN
    if (obs !== {32'd7006652, 5'b00000} || lat != W + 1) begin
      errors++;
      $display("FAIL mul: res=%h zncvi=%b lat=%0d expected res=%h zncvi=00000 lat=%0d",
               obs[W+4:5], obs[4:0], lat, 32'd7006652, W + 1);
    end
`else
    if (obs !== {32'd0, 5'b10001} || lat != 1) begin
      errors++;
      $display("FAIL mul_illegal: res=%h zncvi=%b lat=%0d expected res=0 zncvi=10001 lat=1",
               obs[W+4:5], obs[4:0], lat);
    end
`endif
    release_result();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [W+4:0] obs, held, exp_new;
    logic [W-1:0] na, nb;
    run_op(3'd1, 32'd100, 32'd300, lat, held);
    na = $urandom; nb = $urandom;
    exp_new = model(3'd0, na, nb);
    ALUControl = 3'd0; A = na; B = nb; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      obs = {Result, Zero, Negative, Carry, Overflow, illegal};
      checks++;
      if ({obs, out_valid, in_ready} !== {held, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL hold_%0d: res=%h out_valid=%b in_ready=%b expected res=%h out_valid=1 in_ready=0",
                 i, obs[W+4:5], out_valid, in_ready, held[W+4:5]);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL release_idle: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    obs = {Result, Zero, Negative, Carry, Overflow, illegal};
    checks++;
    if (out_valid !== 1'b1 || obs !== exp_new) begin
      errors++;
      $display("FAIL pending_accept: out_valid=%b res=%h zncvi=%b expected 1 res=%h zncvi=%b",
               out_valid, obs[W+4:5], obs[4:0], exp_new[W+4:5], exp_new[4:0]);
    end
    $display("backpressure request a=%h b=%h res=%h", na, nb, obs[W+4:5]);
    release_result();
  endtask

  task automatic test_reset_mid();
    int lat;
    ALUControl = 3'd6; A = 32'd77; B = 32'd99; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, Result, illegal, in_ready} !== '0) begin
      errors++;
      $display("FAIL reset_abort: out_valid=%b Result=%h illegal=%b in_ready=%b expected all 0",
               out_valid, Result, illegal, in_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_abort_ready: in_ready=%b expected 1", in_ready);
    end
    $display("reset during operation done");
  endtask

  task automatic test_random();
    int lat;
    logic [W+4:0] obs, exp_v;
    logic [2:0] c;
    logic [W-1:0] a, b;
    for (int i = 0; i < 40; i++) begin
      c = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      if ($urandom_range(0, 5) == 0) a = 32'h80000000;
      exp_v = model(c, a, b);
      run_op(c, a, b, lat, obs);
      checks++;
      if (obs !== exp_v || lat != model_lat(c)) begin
        errors++;
        $display("FAIL random_%0d: ctrl=%0d res=%h zncvi=%b lat=%0d expected res=%h zncvi=%b lat=%0d",
                 i, c, obs[W+4:5], obs[4:0], lat, exp_v[W+4:5], exp_v[4:0], model_lat(c));
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      release_result();
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
        errors++;
        $display("FAIL random_idle_%0d: out_valid=%b in_ready=%b expected 0 1", i, out_valid, in_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mul();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
